// File: rtl/gcd_engine.sv
// Handshaked GCD unit: one operand pair in flight, solved by subtractive Euclid
// (mode 0) or binary Stein (mode 1); result, iteration count and zero flag held until consumed.
module gcd_engine #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gcd,
   output logic [CNT_W-1:0] out_iters,
   output logic             out_zero
);

   localparam int K_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_SUB   = 3'd2,
      S_BIN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [CNT_W-1:0] count_q, count_d, iters_q, iters_d, count_inc;
   logic             mode_q, mode_d, zero_q, zero_d;
   logic             a_zero, b_zero, a_eq_b, a_gt_b, a_even, b_even;

   assign a_zero = (a_q == '0);
   assign b_zero = (b_q == '0);
   assign a_eq_b = (a_q == b_q);
   assign a_gt_b = (a_q > b_q);
   assign a_even = ~a_q[0];
   assign b_even = ~b_q[0];

   // The counter sticks at all-ones instead of wrapping; computation itself carries on.
   assign count_inc = (&count_q) ? count_q : count_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         count_q <= '0;
         mode_q  <= 1'b0;
         gcd_q   <= '0;
         iters_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         gcd_q   <= gcd_d;
         iters_q <= iters_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_CHECK;
         S_CHECK: begin
            if (a_zero || b_zero) state_d = S_DONE;
            else if (mode_q)      state_d = S_BIN;
            else                  state_d = S_SUB;
         end
         S_SUB:   if (a_eq_b) state_d = S_DONE;
         S_BIN:   if (a_eq_b) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      count_d = count_q;
      mode_d  = mode_q;
      gcd_d   = gcd_q;
      iters_d = iters_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               mode_d  = in_mode;
               k_d     = '0;
               count_d = '0;
            end
         end
         S_CHECK: begin
            if (a_zero || b_zero) begin
               gcd_d   = a_q | b_q;
               zero_d  = a_zero & b_zero;
               iters_d = '0;
            end
         end
         S_SUB: begin
            count_d = count_inc;
            if (a_eq_b) begin
               gcd_d   = a_q;
               iters_d = count_inc;
               zero_d  = 1'b0;
            end else if (a_gt_b) begin
               a_d = a_q - b_q;
            end else begin
               b_d = b_q - a_q;
            end
         end
         S_BIN: begin
            count_d = count_inc;
            if (a_eq_b) begin
               // Shared factors of two stripped earlier are restored here; cannot overflow.
               gcd_d   = a_q << k_q;
               iters_d = count_inc;
               zero_d  = 1'b0;
            end else if (a_even && b_even) begin
               a_d = a_q >> 1;
               b_d = b_q >> 1;
               k_d = k_q + {{(K_W-1){1'b0}}, 1'b1};
            end else if (a_even) begin
               a_d = a_q >> 1;
            end else if (b_even) begin
               b_d = b_q >> 1;
            end else if (a_gt_b) begin
               a_d = a_q - b_q;
            end else begin
               b_d = b_q - a_q;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   assign out_gcd   = gcd_q;
   assign out_iters = iters_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: vector table on a 16-bit instance plus hand-built
// backpressure, reset-abort and counter-saturation sequences on 8-bit instances.
module tb_gcd_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_mode, out_ready;
   logic        in_ready, out_valid, out_zero;
   logic [15:0] in_a, in_b, out_gcd, out_iters;

   logic        s_in_valid, s_in_mode, s_out_ready;
   logic [7:0]  s_in_a, s_in_b;
   logic        s4_in_ready, s4_out_valid, s4_out_zero;
   logic [7:0]  s4_out_gcd;
   logic [3:0]  s4_out_iters;
   logic        s8_in_ready, s8_out_valid, s8_out_zero;
   logic [7:0]  s8_out_gcd, s8_out_iters;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   gcd_engine #(.WIDTH(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_gcd(out_gcd), .out_iters(out_iters), .out_zero(out_zero)
   );

   gcd_engine #(.WIDTH(8), .CNT_W(4)) dut_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s4_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .in_mode(s_in_mode), .out_valid(s4_out_valid),
      .out_ready(s_out_ready), .out_gcd(s4_out_gcd), .out_iters(s4_out_iters),
      .out_zero(s4_out_zero)
   );

   gcd_engine #(.WIDTH(8), .CNT_W(8)) dut_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s8_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .in_mode(s_in_mode), .out_valid(s8_out_valid),
      .out_ready(s_out_ready), .out_gcd(s8_out_gcd), .out_iters(s8_out_iters),
      .out_zero(s8_out_zero)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        mode;
      logic [15:0] gcd;
      logic [15:0] iters;
      logic        zero;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Latency counts the acceptance cycle as 0, so the first negedge after the accepting edge is 1.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                         output logic [15:0] g, output logic [15:0] it, output logic z,
                         output int lat, output bit ok);
      int n;
      ok = 1'b0;
      g = '0; it = '0; z = 1'b0; lat = 0;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) return;
      in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 16'($urandom_range(0, 65535));
      in_b = 16'($urandom_range(0, 65535));
      in_mode = ~m;
      lat = 1;
      while (!out_valid && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) return;
      g = out_gcd; it = out_iters; z = out_zero;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      ok = 1'b1;
   endtask

   initial begin
      logic [15:0] g, it, e;
      logic z;
      int lat;
      bit ok;

      vecs[0]  = '{16'd48,    16'd18,    1'b0, 16'd6,     16'd5, 1'b0, 7};
      vecs[1]  = '{16'd48,    16'd18,    1'b1, 16'd6,     16'd7, 1'b0, 9};
      vecs[2]  = '{16'd0,     16'd25,    1'b0, 16'd25,    16'd0, 1'b0, 2};
      vecs[3]  = '{16'd0,     16'd25,    1'b1, 16'd25,    16'd0, 1'b0, 2};
      vecs[4]  = '{16'd0,     16'd0,     1'b1, 16'd0,     16'd0, 1'b1, 2};
      vecs[5]  = '{16'd25,    16'd0,     1'b0, 16'd25,    16'd0, 1'b0, 2};
      vecs[6]  = '{16'd7,     16'd7,     1'b0, 16'd7,     16'd1, 1'b0, 3};
      vecs[7]  = '{16'd7,     16'd7,     1'b1, 16'd7,     16'd1, 1'b0, 3};
      vecs[8]  = '{16'd17,    16'd5,     1'b0, 16'd1,     16'd7, 1'b0, 9};
      vecs[9]  = '{16'd17,    16'd5,     1'b1, 16'd1,     16'd8, 1'b0, 10};
      vecs[10] = '{16'd64,    16'd16,    1'b1, 16'd16,    16'd7, 1'b0, 9};
      vecs[11] = '{16'd65535, 16'd65535, 1'b1, 16'd65535, 16'd1, 1'b0, 3};
      vecs[12] = '{16'd100,   16'd75,    1'b0, 16'd25,    16'd4, 1'b0, 6};

      rst_n = 1'b0;
      in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      s_in_valid = 1'b0; s_in_mode = 1'b0; s_out_ready = 1'b0; s_in_a = '0; s_in_b = '0;
      repeat (3) @(negedge clk);
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset out_gcd", out_gcd, 0);
      check("reset out_iters", out_iters, 0);
      check("reset out_zero", out_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         exp_q.push_back(vecs[i].gcd);
         run_op(vecs[i].a, vecs[i].b, vecs[i].mode, g, it, z, lat, ok);
         if (!ok) begin
            check($sformatf("vec%0d timeout", i), 0, 1);
            void'(exp_q.pop_front());
         end else begin
            e = exp_q.pop_front();
            check($sformatf("vec%0d gcd", i), g, e);
            check($sformatf("vec%0d iters", i), it, vecs[i].iters);
            check($sformatf("vec%0d zero", i), z, vecs[i].zero);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d in_ready after handshake", i), in_ready, 1);
            check($sformatf("vec%0d out_valid after handshake", i), out_valid, 0);
         end
      end

      // Backpressure: result must hold while ignored in_valid pulses arrive.
      in_a = 16'd12; in_b = 16'd8; in_mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("bp latency", lat, 5);
      check("bp iters", out_iters, 3);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         in_a = 16'd99; in_b = 16'd33;
         @(negedge clk);
         check($sformatf("bp%0d out_valid", i), out_valid, 1);
         check($sformatf("bp%0d in_ready", i), in_ready, 0);
         check($sformatf("bp%0d out_gcd", i), out_gcd, 4);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp release in_ready", in_ready, 1);
      check("bp release out_valid", out_valid, 0);
      check("bp release gcd kept", out_gcd, 4);
      repeat (3) @(negedge clk);
      check("bp ignored pulses gave no result", out_valid, 0);

      // Reset while computing abandons the operation.
      in_a = 16'd1000; in_b = 16'd3; in_mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("midop busy", in_ready, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort out_gcd", out_gcd, 0);
      check("abort out_iters", out_iters, 0);
      check("abort out_zero", out_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(16'd9, 16'd6, 1'b1, g, it, z, lat, ok);
      check("post-abort completed", ok, 1);
      check("post-abort gcd", g, 3);
      check("post-abort iters", it, 4);
      check("post-abort latency", lat, 6);

      // Counter saturation on 8-bit instances: 255 subtractive iterations.
      s_in_a = 8'd255; s_in_b = 8'd1; s_in_mode = 1'b0; s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      lat = 1;
      while (!(s4_out_valid && s8_out_valid) && lat < 600) begin
         @(negedge clk);
         lat++;
      end
      check("sat latency", lat, 257);
      check("sat cnt4 gcd", s4_out_gcd, 1);
      check("sat cnt4 iters", s4_out_iters, 15);
      check("sat cnt4 zero", s4_out_zero, 0);
      check("sat cnt8 gcd", s8_out_gcd, 1);
      check("sat cnt8 iters", s8_out_iters, 255);
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      check("sat cnt4 in_ready", s4_in_ready, 1);
      check("sat cnt8 in_ready", s8_in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
Parametrised, self-contained GCD unit that merges datapath and controller. It accepts an operand pair over a valid/ready handshake and computes gcd(A,B). Two algorithms are selectable per operation: subtractive Euclid or binary (Stein). The result is returned over a second valid/ready handshake, together with an iteration count and a zero flag. It replaces the fixed-width, start-pulse GCD controller in the arithmetic subsystem.

Parameters:
WIDTH, 16, operand and result width in bits (>=2)
CNT_W, 16, width of the iteration counter; the counter saturates at 2^CNT_W-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  engine can accept operands
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_mode  input  1  0 = subtractive Euclid, 1 = binary Stein
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_gcd  output  WIDTH  gcd(A,B)
out_iters  output  CNT_W  compute-state cycles used (saturating)
out_zero  output  1  both operands were 0

Behaviour:
- One clock. Reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state goes to IDLE. Then in_ready=1, out_valid=0, out_gcd=0, out_iters=0, out_zero=0, and internal A/B/k/count are cleared.
- Reset wins over any in-flight operation. The operation is abandoned and no result is produced.
- States: IDLE, CHECK, SUB, BIN, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance is in_valid & in_ready at an edge. On acceptance, latch in_a/in_b/in_mode, clear k and count, go to CHECK.
  - Inputs are sampled only on the acceptance edge.
- CHECK (one cycle, in_ready=0):
  - If A==0 or B==0: result = A|B, out_zero = (A==0 & B==0), iters=0, go to DONE.
  - Else go to SUB if mode=0, or BIN if mode=1.
- SUB (per cycle, count += 1, saturating):
  - A==B: result=A, go to DONE.
  - A>B: A<=A-B.
  - Otherwise: B<=B-A.
- BIN (per cycle, count += 1, saturating):
  - A==B: result = A<<k, go to DONE.
  - Both even: A>>=1, B>>=1, k+=1.
  - Only A even: A>>=1.
  - Only B even: B>>=1.
  - Both odd: subtract the smaller from the larger, as in SUB.
  - k is clog2(WIDTH+1) bits. A<<k never overflows WIDTH, because gcd <= min(nonzero operands).
- DONE:
  - out_valid=1. out_gcd, out_iters and out_zero are registered and stable until the handshake.
  - On out_ready=1 at an edge: go to IDLE. out_valid drops the next cycle; data outputs keep their last value.
  - out_ready=0 holds the state indefinitely. in_ready stays 0 (backpressure).
- Latency: out_valid rises 2+N cycles after the acceptance edge, where N = compute cycles (N=0 for the zero case).
- Throughput: one operation in flight. in_ready rises the cycle after the output handshake; there is no same-cycle turnaround.
- All arithmetic is unsigned, WIDTH bits. Subtraction never underflows because it is guarded by the compare.
- out_iters saturates at 2^CNT_W-1 and never wraps. Computation continues to completion regardless of saturation.
- in_valid asserted while in_ready=0 is ignored. Operands may change freely when they are not accepted.

Test Plan:
1. mode=0, A=48, B=18 → out_gcd=6, out_iters=5, out_zero=0; out_valid rises 7 cycles after acceptance.
2. mode=1, A=48, B=18 → out_gcd=6, out_iters=7 (path 24/9 k=1, 12/9, 6/9, 3/9, 3/6, 3/3).
3. Zero cases, any mode:
   - (0,25) → out_gcd=25, out_iters=0, out_zero=0.
   - (0,0) → out_gcd=0, out_zero=1.
   - Both valid 2 cycles after acceptance.
4. Backpressure: run (12,8) with out_ready=0 for 10 cycles → out_gcd=4 held stable, in_ready=0, in_valid pulses ignored; then out_ready=1 → IDLE, in_ready=1 the next cycle.
5. WIDTH=8, CNT_W=4, mode=0, (255,1) → out_gcd=1, out_iters=15 (saturated). Repeat with CNT_W=8 → out_iters=255.
6. Reset mid-operation: accept (1000,3) mode=0, drive rst_n=0 after 5 cycles → the next edge gives IDLE, out_valid=0, outputs 0. A following (9,6) mode=1 yields out_gcd=3 correctly.
